sys_control_tx: RTL

- TX-side scheduler for the shared UART transmitter.
- Accepts one-cycle send requests from the RX controller: an 8-bit register-file read result and a 16-bit ALU result.
- Buffers one pending request per source and arbitrates round-robin between them.
- Serializes the ALU result as two bytes, LSB first, and handshakes each byte with the UART TX busy flag.

---
 rtl/sys_ctrl_pkg.sv | 41 ++++
 rtl/sys_control_tx_if.sv | 54 +++++
 rtl/tx_req_slot.sv | 49 ++++
 rtl/sys_control_tx.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller TX path.
// Contents:
//   TX_WIDTH   - default UART byte width
//   tx_state_t - TX scheduler FSM states
//   src_t      - request source identifiers (register file / ALU)
//   rx_cmd_t   - command bytes decoded by the RX controller
//   is_issue() - true for the states that offer a byte to the UART
package sys_ctrl_pkg;

  localparam int TX_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE,
    RF_ISSUE,
    RF_WAIT_HI,
    RF_WAIT_LO,
    ALU_LSB_ISSUE,
    ALU_LSB_WAIT_HI,
    ALU_LSB_WAIT_LO,
    ALU_MSB_ISSUE,
    ALU_MSB_WAIT_HI,
    ALU_MSB_WAIT_LO
  } tx_state_t;

  typedef enum logic {
    SRC_RF,
    SRC_ALU
  } src_t;

  typedef enum logic [7:0] {
    CMD_AA = 8'hAA,
    CMD_BB = 8'hBB,
    CMD_CC = 8'hCC,
    CMD_DD = 8'hDD
  } rx_cmd_t;

  function automatic logic is_issue(input tx_state_t s);
    return (s == RF_ISSUE) || (s == ALU_LSB_ISSUE) || (s == ALU_MSB_ISSUE);
  endfunction

endpackage

// File: rtl/sys_control_tx_if.sv
// Bus bundle between the RX controller / UART TX and the TX scheduler.
// Signals:
//   rf_send_in / rf_send_data_in     - register-file byte send pulse + data
//   alu_send_in / alu_send_data_in   - ALU result send pulse + 2*WIDTH data
//   uart_tx_busy_in                  - UART TX is transmitting a frame
//   uart_tx_data_out                 - byte presented to the UART TX
//   uart_tx_data_valid_out           - byte offered (accepted when busy=0)
//   tx_idle_out                      - scheduler idle, nothing pending
//   rf_overrun_out / alu_overrun_out - pending request overwritten pulses
// Modports: slave = the scheduler, master = the driving environment.
interface sys_control_tx_if
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH = TX_WIDTH
);

  logic                 rf_send_in;
  logic [WIDTH-1:0]     rf_send_data_in;
  logic                 alu_send_in;
  logic [2*WIDTH-1:0]   alu_send_data_in;
  logic                 uart_tx_busy_in;
  logic [WIDTH-1:0]     uart_tx_data_out;
  logic                 uart_tx_data_valid_out;
  logic                 tx_idle_out;
  logic                 rf_overrun_out;
  logic                 alu_overrun_out;

  modport slave (
    input  rf_send_in,
    input  rf_send_data_in,
    input  alu_send_in,
    input  alu_send_data_in,
    input  uart_tx_busy_in,
    output uart_tx_data_out,
    output uart_tx_data_valid_out,
    output tx_idle_out,
    output rf_overrun_out,
    output alu_overrun_out
  );

  modport master (
    output rf_send_in,
    output rf_send_data_in,
    output alu_send_in,
    output alu_send_data_in,
    output uart_tx_busy_in,
    input  uart_tx_data_out,
    input  uart_tx_data_valid_out,
    input  tx_idle_out,
    input  rf_overrun_out,
    input  alu_overrun_out
  );

endinterface

// File: rtl/tx_req_slot.sv
// One-entry pending request slot.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   send       - one-cycle request pulse; latches send_data
//   send_data  - request payload (DW bits)
//   grant      - scheduler takes the pending request this cycle
//   pending    - a request is waiting
//   data       - payload of the waiting request
//   overrun    - registered pulse: a waiting, ungranted request was replaced
module tx_req_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          send,
  input  logic [DW-1:0] send_data,
  input  logic          grant,
  output logic          pending,
  output logic [DW-1:0] data,
  output logic          overrun
);

  logic          pending_reg;
  logic [DW-1:0] data_reg;
  logic          overrun_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      // A grant in the same cycle means the old value is being consumed,
      // so the new pulse simply refills the slot without loss.
      overrun_reg <= send && pending_reg && !grant;
      if (send) begin
        pending_reg <= 1'b1;
        data_reg    <= send_data;
      end else if (grant) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign pending = pending_reg;
  assign data    = data_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/sys_control_tx.sv
// TX-side scheduler for the shared UART transmitter.
// Buffers one register-file byte and one ALU word, arbitrates round-robin
// between them and feeds the UART one byte per frame (ALU word LSB first).
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - sys_control_tx_if.slave: request inputs, UART handshake,
//           idle and overrun status
module sys_control_tx
  import sys_ctrl_pkg::*;
#(
  parameter int WIDTH = TX_WIDTH
) (
  input logic              clk,
  input logic              reset,
  sys_control_tx_if.slave  bus
);

  logic                 rf_pending;
  logic [WIDTH-1:0]     rf_data;
  logic                 rf_overrun;
  logic                 alu_pending;
  logic [2*WIDTH-1:0]   alu_data;
  logic                 alu_overrun;
  logic                 rf_grant;
  logic                 alu_grant;

  tx_state_t            state_reg;
  src_t                 last_grant_reg;
  logic [WIDTH-1:0]     tx_hold_reg;
  logic [WIDTH-1:0]     msb_hold_reg;
  logic                 tx_idle_reg;

  tx_req_slot #(.DW(WIDTH)) u_rf_slot (
    .clk       (clk),
    .reset     (reset),
    .send      (bus.rf_send_in),
    .send_data (bus.rf_send_data_in),
    .grant     (rf_grant),
    .pending   (rf_pending),
    .data      (rf_data),
    .overrun   (rf_overrun)
  );

  tx_req_slot #(.DW(2*WIDTH)) u_alu_slot (
    .clk       (clk),
    .reset     (reset),
    .send      (bus.alu_send_in),
    .send_data (bus.alu_send_data_in),
    .grant     (alu_grant),
    .pending   (alu_pending),
    .data      (alu_data),
    .overrun   (alu_overrun)
  );

  // Grants are only issued from IDLE; on a tie the source that was not
  // granted last time wins.
  always_comb begin
    rf_grant  = 1'b0;
    alu_grant = 1'b0;
    if (state_reg == IDLE) begin
      if (rf_pending && alu_pending) begin
        if (last_grant_reg == SRC_ALU) begin
          rf_grant = 1'b1;
        end else begin
          alu_grant = 1'b1;
        end
      end else begin
        rf_grant  = rf_pending;
        alu_grant = alu_pending;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= SRC_ALU;
      tx_hold_reg    <= '0;
      msb_hold_reg   <= '0;
      tx_idle_reg    <= 1'b1;
    end else begin
      tx_idle_reg <= (state_reg == IDLE) && !rf_pending && !alu_pending;

      case (state_reg)
        IDLE: begin
          // last_grant only moves on a tie so that a lone request does not
          // disturb the round-robin order.
          if (rf_pending && alu_pending) begin
            last_grant_reg <= rf_grant ? SRC_RF : SRC_ALU;
          end
          if (rf_grant) begin
            tx_hold_reg <= rf_data;
            state_reg   <= RF_ISSUE;
          end else if (alu_grant) begin
            tx_hold_reg  <= alu_data[WIDTH-1:0];
            msb_hold_reg <= alu_data[2*WIDTH-1:WIDTH];
            state_reg    <= ALU_LSB_ISSUE;
          end
        end

        RF_ISSUE: begin
          if (!bus.uart_tx_busy_in) state_reg <= RF_WAIT_HI;
        end
        RF_WAIT_HI: begin
          if (bus.uart_tx_busy_in) state_reg <= RF_WAIT_LO;
        end
        RF_WAIT_LO: begin
          if (!bus.uart_tx_busy_in) state_reg <= IDLE;
        end

        ALU_LSB_ISSUE: begin
          if (!bus.uart_tx_busy_in) state_reg <= ALU_LSB_WAIT_HI;
        end
        ALU_LSB_WAIT_HI: begin
          if (bus.uart_tx_busy_in) state_reg <= ALU_LSB_WAIT_LO;
        end
        ALU_LSB_WAIT_LO: begin
          if (!bus.uart_tx_busy_in) begin
            tx_hold_reg <= msb_hold_reg;
            state_reg   <= ALU_MSB_ISSUE;
          end
        end

        ALU_MSB_ISSUE: begin
          if (!bus.uart_tx_busy_in) state_reg <= ALU_MSB_WAIT_HI;
        end
        ALU_MSB_WAIT_HI: begin
          if (bus.uart_tx_busy_in) state_reg <= ALU_MSB_WAIT_LO;
        end
        ALU_MSB_WAIT_LO: begin
          if (!bus.uart_tx_busy_in) state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // The offer follows busy combinationally so a byte is presented in the
  // very cycle the UART becomes free.
  assign bus.uart_tx_data_valid_out = is_issue(state_reg) && !bus.uart_tx_busy_in;
  assign bus.uart_tx_data_out       = tx_hold_reg;
  assign bus.tx_idle_out            = tx_idle_reg;
  assign bus.rf_overrun_out         = rf_overrun;
  assign bus.alu_overrun_out        = alu_overrun;

endmodule
